reg_telemetry_tx: RTL and testbench
===================================

# reg_telemetry_tx

Downstream consumer of the processor top level's six debug register outputs (`d0`–`d5`). On a start pulse it snapshots all six 32-bit words and streams them as a framed 8N1 UART byte sequence on a single `tx` pin. This makes register state observable on a host terminal without a logic analyser. It sits beside the top level on the FPGA board wrapper and has no feedback path into the processor.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal values are ≥ 2.

Ports:
- `clock`  in  1: single system clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: level-sampled request; accepted only in IDLE.
- `d0`…`d5`  in  32 each: register values to report.
- `tx`  out  1: UART serial line, idle high.
- `busy`  out  1: high from the cycle after acceptance until the frame completes.
- `frame_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, FSM=IDLE, all counters=0.
- Acceptance: `start`=1 at a rising edge while in IDLE. On that edge all six words are latched into the snapshot registers. Later changes on `d0`–`d5` do not affect the frame in flight.
- `start` while `busy` is ignored and is not queued.
- Frame byte order:
  - byte 0: sync byte 0xA5.
  - bytes 1–24: `d0` through `d5`, each word big-endian (bits [31:24] first).
  - byte 25: checksum, only when the checksum feature is compiled in (see Configuration).
- Byte format (8N1): one start bit (0), eight data bits LSB first, one stop bit (1).
- Bytes are sent back-to-back with no idle bits between them.
- FSM states:
  - IDLE → START_BIT on acceptance.
  - START_BIT → DATA_BITS after `BAUD_DIV` cycles.
  - DATA_BITS → STOP_BIT after 8 bits.
  - STOP_BIT → START_BIT if more bytes remain, else → DONE.
  - DONE → IDLE after one cycle, asserting `frame_done`.
- Counters:
  - baud counter runs 0..`BAUD_DIV`-1 and wraps.
  - bit counter runs 0..7.
  - byte index runs 0..`FRAME_BYTES`-1.
  - All counters clear on entry to IDLE.
- Asynchronous reset mid-frame: the frame is abandoned immediately. `tx` returns high and no `frame_done` is pulsed.
- `start` held high continuously: a new frame is accepted on the edge where the FSM is back in IDLE. That edge is the cycle after the `frame_done` pulse.

## Timing
- `tx` and `busy` are registered outputs.
- Edge E accepts `start`. From the cycle after E: `tx`=0 (start bit) and `busy`=1.
- Each bit holds for exactly `BAUD_DIV` cycles. Each byte occupies 10·`BAUD_DIV` cycles.
- Frame length: `FRAME_BYTES`·10·`BAUD_DIV` cycles (25 bytes, or 26 with checksum).
- `frame_done`=1 and `busy`=0 in the single cycle immediately after the last stop bit's final cycle.
- `tx`=1 throughout that cycle.
- Earliest next acceptance is the edge ending that cycle.

## Configuration
- Macro: `REG_TELEM_CHECKSUM_EN`.
- Defined: `FRAME_BYTES`=26. Byte 25 is the XOR of bytes 1–24; the sync byte is excluded. The XOR accumulates as each data byte is loaded.
- Undefined: `FRAME_BYTES`=25. No checksum logic or register is synthesised.

## Structure
- Shared package `reg_telem_pkg` holds:
  - FSM state encoding (IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE).
  - `SYNC_BYTE`=8'hA5.
  - `NUM_WORDS`=6.
  - `FRAME_BYTES`, conditioned on `REG_TELEM_CHECKSUM_EN`.
- Sub-module `uart_tx_byte`:
  - Serializes one byte with a valid/ready handshake and owns the baud and bit counters.
  - The parent FSM sequences bytes, handles the snapshot, and computes the checksum.

## Test plan
All scenarios use `BAUD_DIV`=4.
- Reset release then idle 100 cycles → `tx`=1, `busy`=0, `frame_done` never pulses.
- `d0`=32'h12345678, `d1`–`d5`=0, one-cycle `start` → decoded bytes A5 12 34 56 78 followed by twenty 00. `frame_done` pulses exactly 1000 cycles after the first start-bit cycle (1040 with checksum; checksum byte = 0x08).
- Change `d0` to 32'hFFFFFFFF during byte 2 → frame still carries 12 34 56 78.
- Pulse `start` mid-frame → ignored; exactly one frame emitted.
- Hold `start` high → consecutive frames separated by exactly one idle cycle (`tx`=1, `frame_done`=1).
- Assert `reset` low during byte 10 → `tx`=1 within the same cycle and `busy`=0. After release, a new `start` yields a complete, correct frame.

Source files
------------

// File: rtl/reg_telem_pkg.sv
// rtl/reg_telem_pkg.sv - shared state encodings, frame constants and byte helper for reg_telemetry_tx
//
// Build option: REG_TELEM_CHECKSUM_EN appends an XOR checksum byte to every frame.
package reg_telem_pkg;

  // Per-byte line phases walked by uart_tx_byte; DONE is the frame-complete phase.
  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } tx_state_t;

  // Frame-level sequencing in the top level.
  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_SEND,
    FRAME_DONE
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         NUM_WORDS = 6;

`ifdef REG_TELEM_CHECKSUM_EN
  localparam int FRAME_BYTES = 26;
`else
  localparam int FRAME_BYTES = 25;
`endif

  // Wide enough to index every byte of the longest frame.
  localparam int IDX_W = 5;

  // Lane 0 is the most significant byte, which goes on the wire first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serializer for one byte with a valid/ready load handshake
//
// Ports:
//   clock     rising-edge system clock
//   reset     asynchronous active-low reset
//   s_tdata   byte to send
//   s_tvalid  s_tdata is offered
//   s_tready  a byte can be taken this cycle (idle, or last cycle of a stop bit)
//   tx        registered serial line, idle high
//
// Owns the baud and bit counters. Because s_tready is also high in the final
// stop-bit cycle, a byte offered there starts its start bit with no idle gap.
module uart_tx_byte
  import reg_telem_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic       tx
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign s_tready = (state_q == IDLE) || ((state_q == STOP_BIT) && bit_end);
  assign tx       = tx_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    if (s_tvalid && s_tready) begin
      state_d = START_BIT;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = s_tdata;
      tx_d    = 1'b0;
    end else begin
      case (state_q)
        START_BIT, DATA_BITS: begin
          if (bit_end) begin
            baud_d = '0;
            if ((state_q == DATA_BITS) && (bit_q == 3'd7)) begin
              state_d = STOP_BIT;
              tx_d    = 1'b1;
            end else begin
              // The shifter's LSB is always the next data bit to drive.
              state_d = DATA_BITS;
              tx_d    = shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
              if (state_q == DATA_BITS) bit_d = bit_q + 3'd1;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_telemetry_tx.sv
// rtl/reg_telemetry_tx.sv - snapshots six debug words and streams them as a framed UART sequence
//
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous active-low reset
//   start       level-sampled frame request
//   d0..d5      32-bit register values to report
//   tx          UART line, idle high (registered)
//   busy        frame in flight (registered)
//   frame_done  one-cycle pulse in the cycle after the last stop bit
//
// Frame: 0xA5, then d0..d5 big-endian, then (with REG_TELEM_CHECKSUM_EN)
// the XOR of the 24 data bytes.
module reg_telemetry_tx
  import reg_telem_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  input  logic [31:0] d4,
  input  logic [31:0] d5,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] DATA_BYTES = IDX_W'(NUM_WORDS * 4);

  frame_state_t     fstate_q, fstate_d;
  logic [31:0]      snap_q [NUM_WORDS];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       byte_tdata;
  logic             byte_tvalid;
  logic             byte_tready;
  logic             load;
  logic             accept;
`ifdef REG_TELEM_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .clock    (clock),
    .reset    (reset),
    .s_tdata  (byte_tdata),
    .s_tvalid (byte_tvalid),
    .s_tready (byte_tready),
    .tx       (tx)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fstate_q <= FRAME_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) snap_q[i] <= '0;
`ifdef REG_TELEM_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      fstate_q <= fstate_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (accept) snap_q <= '{d0, d1, d2, d3, d4, d5};
`ifdef REG_TELEM_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  always_comb begin
    // idx_q is the byte on the wire; the data byte offered next (idx_q + 1)
    // sits at data offset idx_q, i.e. word idx_q/4, lane idx_q%4.
    byte_tdata = word_byte(snap_q[idx_q[4:2]], idx_q[1:0]);
`ifdef REG_TELEM_CHECKSUM_EN
    if (idx_q == DATA_BYTES) byte_tdata = chk_q;
`endif
    if (fstate_q != FRAME_SEND) byte_tdata = SYNC_BYTE;

    byte_tvalid = (fstate_q == FRAME_SEND) ? (idx_q != LAST_IDX) : start;
    load        = byte_tvalid && byte_tready;
    accept      = load && (fstate_q != FRAME_SEND);

    fstate_d = fstate_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef REG_TELEM_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    case (fstate_q)
      // FRAME_DONE is the single idle-line cycle after a frame. The serializer
      // is already idle there, so a request taken on its closing edge gives
      // back-to-back frames separated by exactly that one cycle.
      FRAME_IDLE, FRAME_DONE: begin
        fstate_d = FRAME_IDLE;
        idx_d    = '0;
        busy_d   = 1'b0;
        if (start) begin
          fstate_d = FRAME_SEND;
          busy_d   = 1'b1;
`ifdef REG_TELEM_CHECKSUM_EN
          chk_d    = '0;
`endif
        end
      end
      FRAME_SEND: begin
        if (load) begin
          idx_d = idx_q + 1'b1;
`ifdef REG_TELEM_CHECKSUM_EN
          if (idx_q < DATA_BYTES) chk_d = chk_q ^ byte_tdata;
`endif
        end else if (byte_tready) begin
          // Last byte's final stop-bit cycle with nothing left to offer.
          fstate_d = FRAME_DONE;
          idx_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        fstate_d = FRAME_IDLE;
        idx_d    = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_telemetry_tx.sv
// tb/tb_reg_telemetry_tx.sv - randomized self-checking bench for reg_telemetry_tx
`timescale 1ns/1ps
module tb_reg_telemetry_tx;

  localparam int B = 4;
`ifdef REG_TELEM_CHECKSUM_EN
  localparam int FB = 26;
`else
  localparam int FB = 25;
`endif
  localparam int FRAME_CYC = FB * 10 * B;
  localparam int TR = 16384;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
  logic        tx, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic tx_tr [TR];
  logic fd_tr [TR];
  logic busy_tr [TR];

  logic [31:0] words [6];
  logic [7:0]  exp_bytes [26];

  reg_telemetry_tx #(.BAUD_DIV(B)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (cyc < TR) begin
      tx_tr[cyc]   = tx;
      fd_tr[cyc]   = frame_done;
      busy_tr[cyc] = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic model_frame();
    logic [7:0] x;
    x = 8'h00;
    exp_bytes[0] = 8'hA5;
    for (int n = 0; n < 24; n++) begin
      exp_bytes[n + 1] = 8'(words[n / 4] >> (8 * (3 - n % 4)));
      x = x ^ exp_bytes[n + 1];
    end
    exp_bytes[25] = x;
  endtask

  task automatic apply_words();
    d0 = words[0]; d1 = words[1]; d2 = words[2];
    d3 = words[3]; d4 = words[4]; d5 = words[5];
  endtask

  task automatic random_words();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
  endtask

  function automatic logic exp_line(int i);
    int k;
    int b;
    k = i / (10 * B);
    b = (i % (10 * B)) / B;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_bytes[k][b - 1];
  endfunction

  function automatic logic [7:0] decode_byte(int s, int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = tx_tr[s + k * 10 * B + (j + 1) * B + B / 2];
    return v;
  endfunction

  function automatic int wave_mismatches(int s);
    int n = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (tx_tr[s + i] !== exp_line(i)) n++;
    return n;
  endfunction

  function automatic int busy_gaps(int s);
    int n = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (busy_tr[s + i] !== 1'b1) n++;
    return n;
  endfunction

  task automatic pulse_start(output int e);
    @(negedge clock);
    start = 1'b1;
    e = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dc);
    dc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      #1;
      if (frame_done === 1'b1) begin
        dc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int r0;
    int bad_tx = 0, bad_busy = 0, bad_fd = 0;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    reset = 1'b1;
    r0 = cyc;
    repeat (101) @(negedge clock);
    for (int i = 0; i < 100; i++) begin
      if (tx_tr[r0 + i] !== 1'b1) bad_tx++;
      if (busy_tr[r0 + i] !== 1'b0) bad_busy++;
      if (fd_tr[r0 + i] !== 1'b0) bad_fd++;
    end
    checks++; if (bad_tx != 0) begin errors++; $display("FAIL idle_tx bad cycles %0d want 0", bad_tx); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy bad cycles %0d want 0", bad_busy); end
    checks++; if (bad_fd != 0) begin errors++; $display("FAIL idle_fd pulses %0d want 0", bad_fd); end
  endtask

  task automatic test_basic();
    int e, s, dc, n;
    words[0] = 32'h12345678;
    for (int i = 1; i < 6; i++) words[i] = 32'h0;
    apply_words();
    model_frame();
    pulse_start(e);
    s = e + 1;
    wait_done(FRAME_CYC + 50, dc);
    checks++; if (dc != s + FRAME_CYC) begin errors++; $display("FAIL basic_done_cycle got %0d want %0d", dc, s + FRAME_CYC); end
    for (int k = 0; k < FB; k++) begin
      checks++;
      if (decode_byte(s, k) !== exp_bytes[k]) begin
        errors++; $display("FAIL basic_byte%0d got %h want %h", k, decode_byte(s, k), exp_bytes[k]);
      end
    end
    n = wave_mismatches(s);
    checks++; if (n != 0) begin errors++; $display("FAIL basic_wave bad cycles %0d want 0", n); end
    n = busy_gaps(s);
    checks++; if (n != 0) begin errors++; $display("FAIL basic_busy low cycles %0d want 0", n); end
    checks++; if (busy_tr[s + FRAME_CYC] !== 1'b0 || tx_tr[s + FRAME_CYC] !== 1'b1) begin
      errors++; $display("FAIL basic_done_cycle_line busy %b tx %b want 0 1", busy_tr[s + FRAME_CYC], tx_tr[s + FRAME_CYC]);
    end
  endtask

  task automatic test_snapshot();
    int e, s, dc, n;
    random_words();
    words[0] = 32'h12345678;
    apply_words();
    model_frame();
    pulse_start(e);
    s = e + 1;
    while (cyc < s + 2 * 10 * B + 5) @(negedge clock);
    d0 = 32'hFFFFFFFF;
    d3 = ~words[3];
    wait_done(FRAME_CYC + 50, dc);
    checks++; if (dc != s + FRAME_CYC) begin errors++; $display("FAIL snap_done_cycle got %0d want %0d", dc, s + FRAME_CYC); end
    for (int k = 0; k < FB; k++) begin
      checks++;
      if (decode_byte(s, k) !== exp_bytes[k]) begin
        errors++; $display("FAIL snap_byte%0d got %h want %h", k, decode_byte(s, k), exp_bytes[k]);
      end
    end
    n = wave_mismatches(s);
    checks++; if (n != 0) begin errors++; $display("FAIL snap_wave bad cycles %0d want 0", n); end
  endtask

  task automatic test_start_ignored();
    int e, s, dc, n, extra_fd, extra_low;
    random_words();
    apply_words();
    model_frame();
    pulse_start(e);
    s = e + 1;
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(20, 250)) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(FRAME_CYC + 50, dc);
    checks++; if (dc != s + FRAME_CYC) begin errors++; $display("FAIL ign_done_cycle got %0d want %0d", dc, s + FRAME_CYC); end
    n = wave_mismatches(s);
    checks++; if (n != 0) begin errors++; $display("FAIL ign_wave bad cycles %0d want 0", n); end
    repeat (61) @(negedge clock);
    extra_fd = 0;
    extra_low = 0;
    for (int i = 1; i <= 60; i++) begin
      if (fd_tr[dc + i] !== 1'b0) extra_fd++;
      if (tx_tr[dc + i] !== 1'b1) extra_low++;
    end
    checks++; if (extra_fd != 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", extra_fd); end
    checks++; if (extra_low != 0) begin errors++; $display("FAIL ign_extra_tx got %0d low cycles want 0", extra_low); end
  endtask

  task automatic test_back_to_back();
    int e, dc1, dc2, dc3, n, tail;
    random_words();
    apply_words();
    model_frame();
    @(negedge clock);
    start = 1'b1;
    e = cyc;
    wait_done(FRAME_CYC + 50, dc1);
    wait_done(FRAME_CYC + 50, dc2);
    @(negedge clock);
    start = 1'b0;
    wait_done(FRAME_CYC + 50, dc3);
    checks++; if (dc1 != e + 1 + FRAME_CYC) begin errors++; $display("FAIL b2b_done1 got %0d want %0d", dc1, e + 1 + FRAME_CYC); end
    checks++; if (dc2 != dc1 + 1 + FRAME_CYC) begin errors++; $display("FAIL b2b_done2 got %0d want %0d", dc2, dc1 + 1 + FRAME_CYC); end
    checks++; if (dc3 != dc2 + 1 + FRAME_CYC) begin errors++; $display("FAIL b2b_done3 got %0d want %0d", dc3, dc2 + 1 + FRAME_CYC); end
    checks++; if (tx_tr[dc1] !== 1'b1 || busy_tr[dc1] !== 1'b0 || fd_tr[dc1] !== 1'b1) begin
      errors++; $display("FAIL b2b_gap tx %b busy %b fd %b want 1 0 1", tx_tr[dc1], busy_tr[dc1], fd_tr[dc1]);
    end
    n = wave_mismatches(e + 1) + wave_mismatches(dc1 + 1) + wave_mismatches(dc2 + 1);
    checks++; if (n != 0) begin errors++; $display("FAIL b2b_wave bad cycles %0d want 0", n); end
    repeat (21) @(negedge clock);
    tail = 0;
    for (int i = 1; i <= 20; i++) if (tx_tr[dc3 + i] !== 1'b1) tail++;
    checks++; if (tail != 0) begin errors++; $display("FAIL b2b_tail low cycles %0d want 0", tail); end
  endtask

  task automatic test_reset_mid();
    int e, s, dc, n, r1, bad;
    random_words();
    apply_words();
    model_frame();
    pulse_start(e);
    s = e + 1;
    r1 = s + 10 * 10 * B + $urandom_range(0, 10 * B - 1);
    while (cyc < r1) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    r1 = cyc;
    repeat (21) @(negedge clock);
    bad = 0;
    for (int i = 0; i < 20; i++) if (fd_tr[r1 + i] !== 1'b0 || tx_tr[r1 + i] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_quiet bad cycles %0d want 0", bad); end
    random_words();
    apply_words();
    model_frame();
    pulse_start(e);
    s = e + 1;
    wait_done(FRAME_CYC + 50, dc);
    checks++; if (dc != s + FRAME_CYC) begin errors++; $display("FAIL recov_done_cycle got %0d want %0d", dc, s + FRAME_CYC); end
    for (int k = 0; k < FB; k++) begin
      checks++;
      if (decode_byte(s, k) !== exp_bytes[k]) begin
        errors++; $display("FAIL recov_byte%0d got %h want %h", k, decode_byte(s, k), exp_bytes[k]);
      end
    end
    n = wave_mismatches(s);
    checks++; if (n != 0) begin errors++; $display("FAIL recov_wave bad cycles %0d want 0", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
